// File: rtl/qif_spike_monitor.sv
// Spike analysis stage: inter-spike interval capture with a one-entry valid/ready
// holding register, plus a windowed spike-rate counter with a strobed result.
module qif_spike_monitor #(
  parameter int ISI_W = 16,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [ISI_W-1:0] isi_data,
  output logic             isi_valid,
  input  logic             isi_ready,
  output logic             isi_ovf,
  output logic [CNT_W-1:0] rate_count,
  output logic             rate_strobe,
  output logic             spike_seen
);

  localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};
  localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  typedef enum logic {ISI_WAIT_FIRST = 1'b0, ISI_RUN = 1'b1} isi_state_t;
  typedef enum logic {RATE_IDLE = 1'b0, RATE_COUNT = 1'b1} rate_state_t;

  logic             spike_prev_q;
  logic             event_w;

  isi_state_t       isi_state_q, isi_state_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic             spike_seen_q, spike_seen_d;
  logic             sample_vld;
  logic [ISI_W-1:0] sample_val;

  logic [ISI_W-1:0] isi_data_q, isi_data_d;
  logic             isi_valid_q, isi_valid_d;
  logic             isi_ovf_q, isi_ovf_d;

  rate_state_t      rate_state_q, rate_state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] spk_cnt_q, spk_cnt_d;
  logic [CNT_W-1:0] rate_count_q, rate_count_d;
  logic             rate_strobe_q, rate_strobe_d;
  logic [CNT_W-1:0] spk_plus;
  logic             win_last;

  // Rising edge of spike_in; spike_prev tracks even while disabled so a level
  // already high when ena rises is not mistaken for a new spike.
  assign event_w = ena & spike_in & ~spike_prev_q;

  always_comb begin
    isi_state_d  = isi_state_q;
    isi_cnt_d    = isi_cnt_q;
    spike_seen_d = spike_seen_q;
    sample_vld   = 1'b0;
    sample_val   = isi_cnt_q;
    if (ena) begin
      case (isi_state_q)
        ISI_WAIT_FIRST: begin
          if (event_w) begin
            isi_state_d  = ISI_RUN;
            isi_cnt_d    = ISI_ONE;
            spike_seen_d = 1'b1;
          end
        end
        ISI_RUN: begin
          if (event_w) begin
            sample_vld = 1'b1;
            isi_cnt_d  = ISI_ONE;
          end else if (isi_cnt_q != ISI_MAX) begin
            isi_cnt_d = isi_cnt_q + ISI_ONE;
          end
        end
        default: isi_state_d = ISI_WAIT_FIRST;
      endcase
    end
  end

  // Holding register: a new sample may replace an accepted one on the same edge.
  always_comb begin
    isi_data_d  = isi_data_q;
    isi_valid_d = isi_valid_q;
    isi_ovf_d   = isi_ovf_q;
    if (sample_vld) begin
      if (!isi_valid_q || isi_ready) begin
        isi_data_d  = sample_val;
        isi_valid_d = 1'b1;
      end else begin
        isi_ovf_d = 1'b1;
      end
    end else if (isi_valid_q && isi_ready) begin
      isi_valid_d = 1'b0;
    end
  end

  assign spk_plus = (event_w && (spk_cnt_q != CNT_MAX)) ? (spk_cnt_q + CNT_ONE) : spk_cnt_q;
  assign win_last = (win_cnt_q >= (window_len - WIN_ONE));

  always_comb begin
    rate_state_d  = rate_state_q;
    win_cnt_d     = win_cnt_q;
    spk_cnt_d     = spk_cnt_q;
    rate_count_d  = rate_count_q;
    rate_strobe_d = 1'b0;
    case (rate_state_q)
      RATE_IDLE: begin
        win_cnt_d = '0;
        spk_cnt_d = '0;
        if (ena && (window_len != '0)) begin
          rate_state_d = RATE_COUNT;
        end
      end
      RATE_COUNT: begin
        if (ena) begin
          if (window_len == '0) begin
            rate_state_d = RATE_IDLE;
            win_cnt_d    = '0;
            spk_cnt_d    = '0;
          end else if (win_last) begin
            rate_count_d  = spk_plus;
            rate_strobe_d = 1'b1;
            win_cnt_d     = '0;
            spk_cnt_d     = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_ONE;
            spk_cnt_d = spk_plus;
          end
        end
      end
      default: rate_state_d = RATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_prev_q  <= 1'b0;
      isi_state_q   <= ISI_WAIT_FIRST;
      isi_cnt_q     <= '0;
      spike_seen_q  <= 1'b0;
      isi_data_q    <= '0;
      isi_valid_q   <= 1'b0;
      isi_ovf_q     <= 1'b0;
      rate_state_q  <= RATE_IDLE;
      win_cnt_q     <= '0;
      spk_cnt_q     <= '0;
      rate_count_q  <= '0;
      rate_strobe_q <= 1'b0;
    end else begin
      spike_prev_q  <= spike_in;
      isi_state_q   <= isi_state_d;
      isi_cnt_q     <= isi_cnt_d;
      spike_seen_q  <= spike_seen_d;
      isi_data_q    <= isi_data_d;
      isi_valid_q   <= isi_valid_d;
      isi_ovf_q     <= isi_ovf_d;
      rate_state_q  <= rate_state_d;
      win_cnt_q     <= win_cnt_d;
      spk_cnt_q     <= spk_cnt_d;
      rate_count_q  <= rate_count_d;
      rate_strobe_q <= rate_strobe_d;
    end
  end

  assign isi_data    = isi_data_q;
  assign isi_valid   = isi_valid_q;
  assign isi_ovf     = isi_ovf_q;
  assign rate_count  = rate_count_q;
  assign rate_strobe = rate_strobe_q;
  assign spike_seen  = spike_seen_q;

endmodule
